gpo_blink: RTL and testbench

//  General-purpose output slot core: the write-side counterpart of the GPI slot. Drives W

---
 rtl/gpo_blink.sv | 106 ++++++++++
 tb/tb_gpo_blink.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gpo_blink.sv
// rtl/gpo_blink.sv - MMIO general-purpose output slot with set/clear/toggle and per-bit blink engine
module gpo_blink #(
    parameter int W  = 8,
    parameter int PW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic [W-1:0]  dout
);

    localparam logic [4:0] A_DATA   = 5'd0;
    localparam logic [4:0] A_SET    = 5'd1;
    localparam logic [4:0] A_CLR    = 5'd2;
    localparam logic [4:0] A_TGL    = 5'd3;
    localparam logic [4:0] A_EN     = 5'd4;
    localparam logic [4:0] A_PERIOD = 5'd5;
    localparam logic [4:0] A_STATUS = 5'd6;

    logic [W-1:0]  data;
    logic [W-1:0]  blink_en;
    logic [PW-1:0] period;
    logic [PW-1:0] counter;
    logic          phase;

    logic          wr_en;
    logic [W-1:0]  wd;
    logic          engine_active;
    logic          engine_restart;
    logic          period_end;
    logic [32:0]   status_ext;
    logic          unused_bits;

    assign wr_en          = cs && write;
    assign wd             = wr_data[W-1:0];
    assign engine_active  = (blink_en != '0) && (period != '0);
    // Reprogramming the mask or the period restarts the blink cycle from a known point.
    assign engine_restart = wr_en && ((addr == A_EN) || (addr == A_PERIOD));
    assign period_end     = (counter == period - PW'(1));
    assign status_ext     = 33'({phase, counter});

    // The read strobe carries no side effects; upper write/status bits are intentionally dropped.
    assign unused_bits = ^{read, wr_data, status_ext[32]};

    // Register file: data with atomic set/clear/toggle, blink mask and half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data     <= '0;
            blink_en <= '0;
            period   <= '0;
        end else if (wr_en) begin
            case (addr)
                A_DATA:   data     <= wd;
                A_SET:    data     <= data | wd;
                A_CLR:    data     <= data & ~wd;
                A_TGL:    data     <= data ^ wd;
                A_EN:     blink_en <= wd;
                A_PERIOD: period   <= wr_data[PW-1:0];
                default:  ;
            endcase
        end
    end

    // Blink engine: half-period counter that flips phase on its last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (engine_restart || !engine_active) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (period_end) begin
            counter <= '0;
            phase   <= ~phase;
        end else begin
            counter <= counter + PW'(1);
        end
    end

    // Registered pin drive so the outputs never glitch while the mux settles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else begin
            dout <= data ^ (blink_en & {W{phase}});
        end
    end

    // Combinational read mux; SET/CLR/TGL alias DATA on read.
    always_comb begin
        rd_data = '0;
        case (addr)
            A_DATA, A_SET, A_CLR, A_TGL: rd_data = 32'(data);
            A_EN:                        rd_data = 32'(blink_en);
            A_PERIOD:                    rd_data = 32'(period);
            A_STATUS:                    rd_data = status_ext[31:0];
            default:                     rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_gpo_blink.sv
// tb/tb_gpo_blink.sv - self-checking bench for gpo_blink against a cycle-count blink model
module tb_gpo_blink;

    localparam int W  = 8;
    localparam int PW = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [W-1:0] dout;

    int checks = 0;
    int errors = 0;

    gpo_blink #(.W(W), .PW(PW)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    // Model: register contents plus the number of cycles the engine has run since it last restarted.
    logic [W-1:0]    m_data;
    logic [W-1:0]    m_en;
    logic [PW-1:0]   m_per;
    longint unsigned m_t;
    logic [W-1:0]    m_dout;

    function automatic logic m_phase();
        if (m_en == '0 || m_per == '0) return 1'b0;
        return ((m_t / longint'(m_per)) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_status();
        longint unsigned c;
        c = (m_en == '0 || m_per == '0) ? 0 : (m_t % longint'(m_per));
        return {7'd0, m_phase(), c[23:0]};
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd0, 5'd1, 5'd2, 5'd3: return {24'd0, m_data};
            5'd4: return {24'd0, m_en};
            5'd5: return {8'd0, m_per};
            5'd6: return m_status();
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data = '0;
            m_en   = '0;
            m_per  = '0;
            m_t    = 0;
            m_dout = '0;
        end else begin
            m_dout = m_data ^ (m_en & {W{m_phase()}});
            if (cs && write && (addr == 5'd4 || addr == 5'd5)) m_t = 0;
            else if (m_en != '0 && m_per != '0) m_t = m_t + 1;
            else m_t = 0;
            if (cs && write) begin
                case (addr)
                    5'd0: m_data = wr_data[7:0];
                    5'd1: m_data = m_data | wr_data[7:0];
                    5'd2: m_data = m_data & ~wr_data[7:0];
                    5'd3: m_data = m_data ^ wr_data[7:0];
                    5'd4: m_en   = wr_data[7:0];
                    5'd5: m_per  = wr_data[23:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison mid-cycle, away from the active edge.
    always @(negedge clk) begin
        chk("dout_model", {24'd0, dout}, {24'd0, m_dout});
        chk("rd_model", rd_data, m_rd(addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        tick();
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        tick();
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    logic [15:0] pat3;

    initial begin
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        #12;
        for (int a = 0; a < 7; a++) rd_chk("reset_read", 5'(a), 32'd0);
        chk("reset_dout", {24'd0, dout}, 32'd0);
        tick();
        reset = 1'b0;

        // Data register and atomic ops
        wr(5'd0, 32'hA5); tick(); chk("data_a5", {24'd0, dout}, 32'hA5);
        wr(5'd1, 32'h0F); tick(); chk("set_0f", {24'd0, dout}, 32'hAF);
        wr(5'd2, 32'hA0); tick(); chk("clr_a0", {24'd0, dout}, 32'h0F);
        wr(5'd3, 32'hFF); tick(); chk("tgl_ff", {24'd0, dout}, 32'hF0);
        rd_chk("rd_tgl_alias", 5'd3, 32'hF0);

        // Blink with half-period 4 on bit 0
        wr(5'd0, 32'h00); wr(5'd5, 32'd4); wr(5'd4, 32'h01);
        pat3 = 16'hF0F0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("blink4", {24'd0, dout}, {31'd0, pat3[i]});
        end

        // Disabling the mask drops straight back to data
        wr(5'd4, 32'h00);
        rd_chk("status_after_dis", 5'd6, 32'd0);
        tick(); chk("dis_dout", {24'd0, dout}, 32'h00);
        wr(5'd5, 32'd0); wr(5'd4, 32'h01);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("period0_noblink", {24'd0, dout}, 32'h00);
        end

        // Period 1: every cycle toggles
        wr(5'd0, 32'h55); wr(5'd5, 32'd1); wr(5'd4, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("period1", {24'd0, dout}, (i % 2 == 0) ? 32'h55 : 32'hAA);
        end

        // Reset mid-blink at counter 2, phase 1
        wr(5'd0, 32'h00); wr(5'd5, 32'd4); wr(5'd4, 32'hFF);
        for (int i = 0; i < 6; i++) tick();
        rd_chk("status_mid", 5'd6, 32'h0100_0002);
        chk("dout_mid", {24'd0, dout}, 32'hFF);
        #1 reset = 1'b1;
        #1 chk("reset_mid_dout", {24'd0, dout}, 32'h00);
        tick();
        reset = 1'b0;
        for (int a = 0; a < 7; a++) rd_chk("post_reset_read", 5'(a), 32'd0);

        // Ignored writes: cs low and unmapped addresses
        wr(5'd0, 32'h3C);
        tick();
        cs = 1'b0; write = 1'b1; addr = 5'd0; wr_data = 32'hFF;
        tick();
        write = 1'b0;
        for (int a = 7; a < 32; a++) wr(5'(a), 32'hFFFF_FFFF);
        for (int a = 7; a < 32; a++) rd_chk("unmapped_read", 5'(a), 32'd0);
        rd_chk("data_kept", 5'd0, 32'h3C);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset   = ($urandom_range(0, 299) == 0);
            cs      = ($urandom_range(0, 3) != 0);
            write   = ($urandom_range(0, 2) == 0);
            read    = $urandom_range(0, 1) == 1;
            addr    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 6));
            wr_data = $urandom;
            if (addr == 5'd5) wr_data = 32'($urandom_range(0, 6)) | (($urandom_range(0, 3) == 0) ? 32'hFF00_0000 : 32'd0);
            if (addr == 5'd4 && $urandom_range(0, 3) == 0) wr_data = 32'd0;
        end
        tick();
        reset = 1'b0; cs = 1'b0; write = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
